// File: rtl/hitspy_pkg.sv
// Shared hitspy definitions: arbiter state encoding, default event length, and
// the header-word field layout used by the hitspy input stages.
package hitspy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } arb_state_e;

  localparam int WORDS_PER_EVT_DEF = 7;

  // Header word: hitmap in the low bits, missing-hit flags and layer count above.
  localparam int HDR_HITMAP_LSB = 0;
  localparam int HDR_HITMAP_W   = 16;
  localparam int HDR_MISS_LSB   = 16;
  localparam int HDR_MISS_W     = 8;
  localparam int HDR_NLAYER_LSB = 24;
  localparam int HDR_NLAYER_W   = 4;

  typedef struct packed {
    logic [HDR_NLAYER_W-1:0] n_layers;
    logic [HDR_MISS_W-1:0]   missing;
    logic [HDR_HITMAP_W-1:0] hitmap;
  } hdr_fields_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >>> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

  function automatic hdr_fields_t hdr_unpack(input logic [31:0] word);
    hdr_fields_t f;
    f.hitmap   = word[HDR_HITMAP_LSB +: HDR_HITMAP_W];
    f.missing  = word[HDR_MISS_LSB +: HDR_MISS_W];
    f.n_layers = word[HDR_NLAYER_LSB +: HDR_NLAYER_W];
    return f;
  endfunction

endpackage

// File: rtl/hitspy_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index at or
// after the pointer, wrapping cyclically.
module hitspy_rr_pick
  import hitspy_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             any_req_o
);

  logic [IDX_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set bit wins last.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_o = '0;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(ptr_i) + k) % N_REQ);
      if (req_i[idx]) grant_o = idx;
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/hitspy_event_arbiter.sv
// Round-robin event arbiter streaming whole hitspy events onto the fitter bus.
// Optional stall watchdog with drain: define HITSPY_ARB_TIMEOUT_EN.
module hitspy_event_arbiter
  import hitspy_pkg::*;
#(
  parameter  int N_REQ         = 4,
  parameter  int WORDS_PER_EVT = WORDS_PER_EVT_DEF,
  parameter  int DW            = 32,
  parameter  int TIMEOUT_CYC   = 256,
  localparam int SRC_W         = clog2(N_REQ)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] src_data,
  output logic [N_REQ-1:0]    rd_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic                out_last,
  output logic [SRC_W-1:0]    out_src,
  output logic                busy,
  output logic                err_timeout
);

  localparam int               CNT_W    = clog2(WORDS_PER_EVT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_EVT - 1);
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SRC_W-1:0] grant;
  logic             any_req;
  logic             pop;
  logic             at_last;

`ifdef HITSPY_ARB_TIMEOUT_EN
  localparam int               STALL_W    = clog2(TIMEOUT_CYC);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);

  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_q, err_d;
`endif

  hitspy_rr_pick #(
    .N_REQ(N_REQ)
  ) u_rr_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .grant_o  (grant),
    .any_req_o(any_req)
  );

  assign at_last = (cnt_q == LAST_CNT);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    src_d     = src_q;
    cnt_d     = cnt_q;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    pop       = 1'b0;
`ifdef HITSPY_ARB_TIMEOUT_EN
    stall_d   = '0;
    err_d     = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          src_d   = grant;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        out_valid = 1'b1;
        out_last  = at_last;
        busy      = 1'b1;
        pop       = out_ready;
`ifdef HITSPY_ARB_TIMEOUT_EN
        if (!out_ready) begin
          if (stall_q == STALL_LAST) begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
`endif
      end
`ifdef HITSPY_ARB_TIMEOUT_EN
      ST_DRAIN: begin
        // Discard the rest of the abandoned event so the buffer stays aligned.
        pop = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Shared word accounting for both streamed and drained pops.
    if (pop) begin
      if (at_last) begin
        cnt_d   = '0;
        ptr_d   = (src_q == LAST_SRC) ? '0 : src_q + SRC_W'(1);
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rd_en        = '0;
    rd_en[src_q] = pop;
  end

  always_comb begin
    out_data = '0;
    if (out_valid) out_data = src_data[int'(src_q)*DW +: DW];
  end

  assign out_src = src_q;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: only control state is reset; out_data is a pure mux and needs none.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HITSPY_ARB_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hitspy_event_arbiter.sv
// Directed bench for hitspy_event_arbiter in its default build (no watchdog).
module tb_hitspy_event_arbiter;

  localparam int N  = 4;
  localparam int W  = 7;
  localparam int DW = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]    rd_en;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [1:0]      out_src;
  logic            busy;
  logic            err_timeout;

  int pop_cnt[N]   = '{default: 0};
  int exp_pops[N]  = '{default: 0};
  int tests_run    = 0;
  int tests_failed = 0;

  hitspy_event_arbiter #(
    .N_REQ        (N),
    .WORDS_PER_EVT(W),
    .DW           (DW),
    .TIMEOUT_CYC  (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .src_data   (src_data),
    .rd_en      (rd_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_src    (out_src),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  // FWFT buffer model: head word encodes buffer id and how many words were popped.
  always @(posedge clock) begin
    for (int i = 0; i < N; i++) if (rd_en[i] === 1'b1) pop_cnt[i] <= pop_cnt[i] + 1;
  end

  always_comb begin
    src_data = '0;
    for (int i = 0; i < N; i++) src_data[i*DW +: DW] = {8'(8'hA0 + i), pop_cnt[i][23:0]};
  end

  function automatic logic [DW-1:0] exp_word(input int i, input int n);
    return {8'(8'hA0 + i), 24'(n)};
  endfunction

  // Grant one event from src and stream it; mode 1 = ready pattern 1,0,0 repeating.
  task automatic stream_event(input int src, input int mode, input int drop_after, input string name);
    int         words;
    int         cyc;
    logic       rdy;
    logic [N-1:0] exp_rd;
    words = 0;
    cyc   = 0;
    @(posedge clock); #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_src !== 2'(src)) begin
      tests_failed++;
      $display("FAIL %s grant: valid=%b src=%0d, want valid=1 src=%0d", name, out_valid, out_src, src);
    end
    while (words < W && cyc < 64) begin
      if (words == drop_after) req = '0;
      rdy       = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      out_ready = rdy;
      #1;
      exp_rd = rdy ? N'(1 << src) : '0;
      tests_run++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_src !== 2'(src)) begin
        tests_failed++;
        $display("FAIL %s ctrl w%0d: valid=%b busy=%b src=%0d, want 1 1 %0d", name, words, out_valid, busy, out_src, src);
      end
      tests_run++;
      if (out_data !== exp_word(src, exp_pops[src])) begin
        tests_failed++;
        $display("FAIL %s data w%0d: got %h want %h", name, words, out_data, exp_word(src, exp_pops[src]));
      end
      tests_run++;
      if (rd_en !== exp_rd) begin
        tests_failed++;
        $display("FAIL %s rd_en w%0d: got %b want %b", name, words, rd_en, exp_rd);
      end
      tests_run++;
      if (out_last !== (words == W - 1)) begin
        tests_failed++;
        $display("FAIL %s last w%0d: got %b want %b", name, words, out_last, (words == W - 1));
      end
      @(posedge clock); #1;
      if (rdy) begin
        words++;
        exp_pops[src]++;
      end
      cyc++;
    end
    tests_run++;
    if (words != W) begin
      tests_failed++;
      $display("FAIL %s timeout: %0d words in %0d cycles, want %0d", name, words, cyc, W);
    end
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || rd_en !== '0) begin
      tests_failed++;
      $display("FAIL %s bubble: valid=%b busy=%b rd_en=%b, want 0 0 0", name, out_valid, busy, rd_en);
    end
    tests_run++;
    if (pop_cnt[src] !== exp_pops[src]) begin
      tests_failed++;
      $display("FAIL %s pops: buffer %0d popped %0d, want %0d", name, src, pop_cnt[src], exp_pops[src]);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req       = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset flags: valid=%b last=%b busy=%b err=%b, want 0", out_valid, out_last, busy, err_timeout);
    end
    tests_run++;
    if (rd_en !== '0 || out_src !== 2'd0 || out_data !== '0) begin
      tests_failed++;
      $display("FAIL reset data: rd_en=%b src=%0d data=%h, want 0", rd_en, out_src, out_data);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    tests_run++;
    if (out_valid !== 1'b0 || rd_en !== '0) begin
      tests_failed++;
      $display("FAIL idle no req: valid=%b rd_en=%b, want 0", out_valid, rd_en);
    end
  endtask

  task automatic test_single();
    req = 4'b0100;
    stream_event(2, 0, 0, "single");
  endtask

  task automatic test_reset_mid();
    req = 4'b0001;
    @(posedge clock); #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_src !== 2'd0) begin
      tests_failed++;
      $display("FAIL rstmid grant: valid=%b src=%0d, want 1 0", out_valid, out_src);
    end
    req       = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (out_data !== exp_word(0, exp_pops[0])) begin
        tests_failed++;
        $display("FAIL rstmid data w%0d: got %h want %h", k, out_data, exp_word(0, exp_pops[0]));
      end
      @(posedge clock); #1;
      exp_pops[0]++;
    end
    out_ready = 1'b0;
    reset     = 1'b1;
    @(posedge clock); #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || rd_en !== '0 || out_src !== 2'd0 || out_data !== '0) begin
      tests_failed++;
      $display("FAIL rstmid outputs: valid=%b last=%b busy=%b rd_en=%b src=%0d data=%h, want all 0",
               out_valid, out_last, busy, rd_en, out_src, out_data);
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (rd_en !== '0) begin
      tests_failed++;
      $display("FAIL rstmid pop in reset: rd_en=%b want 0000", rd_en);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    // Pointer was 3 before reset; from 3 this request would pick buffer 3.
    req = 4'b1010;
    stream_event(1, 0, 0, "rstmid restart");
    tests_run++;
    if (pop_cnt[0] !== exp_pops[0]) begin
      tests_failed++;
      $display("FAIL rstmid abandoned: buffer 0 popped %0d, want %0d", pop_cnt[0], exp_pops[0]);
    end
  endtask

  task automatic test_round_robin();
    req = 4'b1111;
    stream_event(2, 0, -1, "rr0");
    stream_event(3, 0, -1, "rr1");
    stream_event(0, 0, -1, "rr2");
    stream_event(1, 0, -1, "rr3");
    stream_event(2, 0, -1, "rr4");
    req = '0;
  endtask

  task automatic test_backpressure();
    req = 4'b0001;
    stream_event(0, 1, 0, "backpressure");
  endtask

  task automatic test_req_drop();
    req = 4'b0010;
    stream_event(1, 0, 2, "req drop");
  endtask

  task automatic test_pointer_wrap();
    req = '0;
    repeat (3) begin
      @(posedge clock); #1;
      tests_run++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || rd_en !== '0) begin
        tests_failed++;
        $display("FAIL idle hold: valid=%b busy=%b rd_en=%b, want 0", out_valid, busy, rd_en);
      end
    end
    req = 4'b1011;
    stream_event(3, 0, 0, "skip to 3");
    req = 4'b1001;
    stream_event(0, 0, 0, "wrap to 0");
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_reset_mid();
    test_round_robin();
    test_backpressure();
    test_req_drop();
    test_pointer_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
